// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes, operand-A
// select encodings and the immediate-format selector used by decode_imm_gen.
package decode_pkg;

  localparam int unsigned INSTR_BITS = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU_Control codes; branch compares are ALU_BRANCH | funct3
  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_SUB    = 6'b001000;
  localparam logic [5:0] ALU_JUMP   = 6'b011111;
  localparam logic [5:0] ALU_BRANCH = 6'b010000;
  localparam logic [5:0] ALU_SRAI   = 6'b001101;

  // Operand A selects
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_PC4  = 2'b10;
  localparam logic [1:0] OPA_ZERO = 2'b11;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: reassembles and sign-extends the immediate of the
// selected RV32I format.
//   instr_hi : instruction bits [31:7] (opcode bits are not needed here)
//   fmt      : immediate format chosen by the decoder
//   imm32    : sign-extended immediate, zero for IMM_NONE
module decode_imm_gen
  import decode_pkg::*;
(
  input  logic [31:7] instr_hi,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm32
);

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I: imm32 = {{20{instr_hi[31]}}, instr_hi[31:20]};
      IMM_S: imm32 = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
      IMM_B: imm32 = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7],
                      instr_hi[30:25], instr_hi[11:8], 1'b0};
      IMM_U: imm32 = {instr_hi[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                      instr_hi[20], instr_hi[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I single-cycle decoder: register selects, immediate, ALU/operand
// selects, memory/writeback controls and next-PC target, all combinational;
// plus a sticky illegal-instruction flag.
// Build option: DECODE_STRICT_FUNCT_EN also treats bad funct fields as illegal.
// Ports:
//   clock, reset        : clock (flag only), async active-low reset
//   PC, instruction     : current instruction address and word
//   JALR_target, branch : ALU-computed jalr target and branch condition
//   next_PC_select, target_PC : fetch redirect control and address
//   read_sel1/2, write_sel    : raw rs1/rs2/rd fields
//   wEn, branch_op, imm32, op_A_sel, op_B_sel, ALU_Control,
//   mem_wEn, wb_sel           : datapath controls
//   illegal                   : sticky illegal-instruction flag
module decode
  import decode_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [31:0]             instruction,
  input  logic [ADDRESS_BITS-1:0] JALR_target,
  input  logic                    branch,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    branch_op,
  output logic [31:0]             imm32,
  output logic [1:0]              op_A_sel,
  output logic                    op_B_sel,
  output logic [5:0]              ALU_Control,
  output logic                    mem_wEn,
  output logic                    wb_sel,
  output logic                    illegal
);

  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic                    opcode_ok;
  logic                    funct_ok;
  logic                    illegal_instr_c;
  imm_fmt_e                imm_fmt;
  logic [ADDRESS_BITS-1:0] pc_plus4;
  logic [ADDRESS_BITS-1:0] pc_plus_imm;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign funct7    = instruction[31:25];
  assign read_sel1 = instruction[19:15];
  assign read_sel2 = instruction[24:20];
  assign write_sel = instruction[11:7];

  assign pc_plus4    = PC + ADDRESS_BITS'(4);
  assign pc_plus_imm = PC + ADDRESS_BITS'(imm32);

  // Opcode legality
  always_comb begin
    opcode_ok = 1'b0;
    case (opcode)
      OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_ok = 1'b1;
      default: opcode_ok = 1'b0;
    endcase
  end

`ifdef DECODE_STRICT_FUNCT_EN
  // Funct-field legality for the subset the core implements
  always_comb begin
    funct_ok = 1'b1;
    case (opcode)
      OP_R: funct_ok = (funct7 == 7'b0000000) ||
                       ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OP_IALU: begin
        if (funct3 == 3'b001) begin
          funct_ok = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          funct_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end
      end
      OP_LOAD, OP_STORE: funct_ok = (funct3 == 3'b010);
      OP_BRANCH:         funct_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
      OP_JALR:           funct_ok = (funct3 == 3'b000);
      default:           funct_ok = 1'b1;
    endcase
  end
`else
  assign funct_ok = 1'b1;
`endif

  assign illegal_instr_c = !(opcode_ok && funct_ok);

  // Control decode; illegal instructions keep every default
  always_comb begin
    imm_fmt        = IMM_NONE;
    wEn            = 1'b0;
    mem_wEn        = 1'b0;
    wb_sel         = 1'b0;
    branch_op      = 1'b0;
    op_A_sel       = OPA_RS1;
    op_B_sel       = 1'b1;
    ALU_Control    = ALU_ADD;
    target_PC      = pc_plus4;
    next_PC_select = 1'b0;
    if (!illegal_instr_c) begin
      case (opcode)
        OP_R: begin
          wEn         = 1'b1;
          op_B_sel    = 1'b0;
          ALU_Control = {2'b00, funct7[5], funct3};
        end
        OP_IALU: begin
          imm_fmt     = IMM_I;
          wEn         = 1'b1;
          // Only SRAI carries funct7 into the ALU code; other shifts ignore it
          ALU_Control = ((funct3 == 3'b101) && (funct7 == 7'b0100000)) ?
                        ALU_SRAI : {3'b000, funct3};
        end
        OP_LOAD: begin
          imm_fmt = IMM_I;
          wEn     = 1'b1;
          wb_sel  = 1'b1;
        end
        OP_STORE: begin
          imm_fmt = IMM_S;
          mem_wEn = 1'b1;
        end
        OP_BRANCH: begin
          imm_fmt        = IMM_B;
          branch_op      = 1'b1;
          op_B_sel       = 1'b0;
          ALU_Control    = ALU_BRANCH | {3'b000, funct3};
          target_PC      = pc_plus_imm;
          next_PC_select = branch;
        end
        OP_JAL: begin
          imm_fmt        = IMM_J;
          wEn            = 1'b1;
          op_A_sel       = OPA_PC4;
          ALU_Control    = ALU_JUMP;
          target_PC      = pc_plus_imm;
          next_PC_select = 1'b1;
        end
        OP_JALR: begin
          imm_fmt        = IMM_I;
          wEn            = 1'b1;
          op_A_sel       = OPA_PC4;
          ALU_Control    = ALU_JUMP;
          target_PC      = JALR_target;
          next_PC_select = 1'b1;
        end
        OP_LUI: begin
          imm_fmt  = IMM_U;
          wEn      = 1'b1;
          op_A_sel = OPA_ZERO;
        end
        OP_AUIPC: begin
          imm_fmt  = IMM_U;
          wEn      = 1'b1;
          op_A_sel = OPA_PC;
        end
        default: imm_fmt = IMM_NONE;
      endcase
    end
  end

  decode_imm_gen u_imm_gen (
    .instr_hi (instruction[31:7]),
    .fmt      (imm_fmt),
    .imm32    (imm32)
  );

  // Sticky illegal flag; reset dominates a simultaneous set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
    end else if (illegal_instr_c) begin
      illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Testbench for decode: directed vector table, sticky-flag sequences and
// randomized instructions checked against a behavioural model.
module tb_decode;

  typedef struct packed {
    logic        npc;
    logic [15:0] tpc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        bop;
    logic [31:0] imm;
    logic [1:0]  opa;
    logic        opb;
    logic [5:0]  alu;
    logic        mwen;
    logic        wbs;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
    logic [15:0] jt;
    logic        br;
    dec_t        exp;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [15:0] PC;
  logic [31:0] instruction;
  logic [15:0] JALR_target;
  logic        branch;
  logic        next_PC_select;
  logic [15:0] target_PC;
  logic [4:0]  read_sel1, read_sel2, write_sel;
  logic        wEn, branch_op, op_B_sel, mem_wEn, wb_sel, illegal;
  logic [31:0] imm32;
  logic [1:0]  op_A_sel;
  logic [5:0]  ALU_Control;

  int n_checks = 0;
  int n_fail   = 0;

  dec_t act;
  assign act = {next_PC_select, target_PC, read_sel1, read_sel2, write_sel, wEn,
                branch_op, imm32, op_A_sel, op_B_sel, ALU_Control, mem_wEn, wb_sel};

  decode #(.ADDRESS_BITS(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .PC             (PC),
    .instruction    (instruction),
    .JALR_target    (JALR_target),
    .branch         (branch),
    .next_PC_select (next_PC_select),
    .target_PC      (target_PC),
    .read_sel1      (read_sel1),
    .read_sel2      (read_sel2),
    .write_sel      (write_sel),
    .wEn            (wEn),
    .branch_op      (branch_op),
    .imm32          (imm32),
    .op_A_sel       (op_A_sel),
    .op_B_sel       (op_B_sel),
    .ALU_Control    (ALU_Control),
    .mem_wEn        (mem_wEn),
    .wb_sel         (wb_sel),
    .illegal        (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic dec_t mk(logic npc, logic [15:0] tpc, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic wen, logic bop, logic [31:0] imm,
                              logic [1:0] opa, logic opb, logic [5:0] alu, logic mwen,
                              logic wbs);
    return {npc, tpc, rs1, rs2, rd, wen, bop, imm, opa, opb, alu, mwen, wbs};
  endfunction

  // Reference model: immediates built arithmetically from the sign-shifted word
  function automatic dec_t model(logic [31:0] i, logic [15:0] pc, logic [15:0] jt, logic br);
    dec_t        d;
    logic [31:0] im_i, im_s, im_b, im_u, im_j;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        bad;
    f3   = i[14:12];
    f7   = i[31:25];
    im_i = 32'($signed(i) >>> 20);
    im_s = (im_i & 32'hFFFF_FFE0) | {27'd0, i[11:7]};
    im_b = (im_s & 32'hFFFF_F7FE) | (32'(i[7]) << 11);
    im_u = i & 32'hFFFF_F000;
    im_j = (im_i & 32'hFFF0_07FE) | (i & 32'h000F_F000) | (32'(i[20]) << 11);
    d     = '0;
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.rd  = i[11:7];
    d.tpc = pc + 16'd4;
    d.opb = 1'b1;
    bad   = 1'b0;
`ifdef DECODE_STRICT_FUNCT_EN
    if (i[6:0] == 7'h33)
      bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    if (i[6:0] == 7'h13 && f3 == 3'd1) bad = (f7 != 7'h00);
    if (i[6:0] == 7'h13 && f3 == 3'd5) bad = !(f7 == 7'h00 || f7 == 7'h20);
    if (i[6:0] == 7'h03 || i[6:0] == 7'h23) bad = (f3 != 3'd2);
    if (i[6:0] == 7'h63) bad = (f3 == 3'd2 || f3 == 3'd3);
    if (i[6:0] == 7'h67) bad = (f3 != 3'd0);
`endif
    if (!bad) begin
      case (i[6:0])
        7'h33: begin d.wen = 1; d.opb = 0; d.alu = {2'b00, f7[5], f3}; end
        7'h13: begin
          d.wen = 1; d.imm = im_i;
          d.alu = (f3 == 3'd5 && f7 == 7'h20) ? 6'd13 : 6'(f3);
        end
        7'h03: begin d.wen = 1; d.wbs = 1; d.imm = im_i; end
        7'h23: begin d.mwen = 1; d.imm = im_s; end
        7'h63: begin
          d.bop = 1; d.opb = 0; d.imm = im_b; d.alu = 6'd16 + 6'(f3);
          d.tpc = pc + 16'(im_b); d.npc = br;
        end
        7'h6F: begin
          d.wen = 1; d.imm = im_j; d.opa = 2; d.alu = 6'd31;
          d.tpc = pc + 16'(im_j); d.npc = 1;
        end
        7'h67: begin
          d.wen = 1; d.imm = im_i; d.opa = 2; d.alu = 6'd31; d.tpc = jt; d.npc = 1;
        end
        7'h37: begin d.wen = 1; d.imm = im_u; d.opa = 3; end
        7'h17: begin d.wen = 1; d.imm = im_u; d.opa = 1; end
        default: ;
      endcase
    end
    return d;
  endfunction

  task automatic check_dec(string name, dec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (instr %h pc %h)", name, act, exp, instruction, PC);
    end
  endtask

  task automatic check_flag(string name, logic exp);
    n_checks++;
    if (illegal !== exp) begin
      n_fail++;
      $display("FAIL %s: illegal got %b expected %b", name, illegal, exp);
    end
  endtask

  localparam logic [31:0] ADDI = 32'hFFF0_0593;
  localparam logic [31:0] BADOP = 32'h0000_007F;

  vec_t vecs[14];

  initial begin
    logic [6:0] ops[10];
    logic [31:0] r;

    vecs[0]  = '{ADDI,          16'h0114, 16'h0154, 1'b0,
                 mk(0, 16'h0118, 0, 31, 11, 1, 0, 32'hFFFF_FFFF, 0, 1, 6'h00, 0, 0)};
    vecs[1]  = '{32'h40E6_0833, 16'h0114, 16'h0154, 1'b0,
                 mk(0, 16'h0118, 12, 14, 16, 1, 0, 32'h0, 0, 0, 6'h08, 0, 0)};
    vecs[2]  = '{32'h00C5_A023, 16'h0114, 16'h0154, 1'b0,
                 mk(0, 16'h0118, 11, 12, 0, 0, 0, 32'h0, 0, 1, 6'h00, 1, 0)};
    vecs[3]  = '{32'h0005_A903, 16'h0114, 16'h0154, 1'b0,
                 mk(0, 16'h0118, 11, 0, 18, 1, 0, 32'h0, 0, 1, 6'h00, 0, 1)};
    vecs[4]  = '{32'h0140_006F, 16'h0114, 16'h0154, 1'b0,
                 mk(1, 16'h0128, 0, 20, 0, 1, 0, 32'h14, 2, 1, 6'h1F, 0, 0)};
    vecs[5]  = '{32'h0002_80E7, 16'h0114, 16'h0154, 1'b0,
                 mk(1, 16'h0154, 5, 0, 1, 1, 0, 32'h0, 2, 1, 6'h1F, 0, 0)};
    vecs[6]  = '{32'h0020_8463, 16'h0114, 16'h0154, 1'b1,
                 mk(1, 16'h011C, 1, 2, 8, 0, 1, 32'h8, 0, 0, 6'h10, 0, 0)};
    vecs[7]  = '{32'h0020_8463, 16'h0114, 16'h0154, 1'b0,
                 mk(0, 16'h011C, 1, 2, 8, 0, 1, 32'h8, 0, 0, 6'h10, 0, 0)};
    vecs[8]  = '{32'hFE00_1EE3, 16'h0114, 16'h0154, 1'b1,
                 mk(1, 16'h0110, 0, 0, 29, 0, 1, 32'hFFFF_FFFC, 0, 0, 6'h11, 0, 0)};
    vecs[9]  = '{32'h0004_02B7, 16'h0114, 16'h0154, 1'b0,
                 mk(0, 16'h0118, 8, 0, 5, 1, 0, 32'h0004_0000, 3, 1, 6'h00, 0, 0)};
    vecs[10] = '{32'h0000_1197, 16'h0114, 16'h0154, 1'b0,
                 mk(0, 16'h0118, 0, 0, 3, 1, 0, 32'h0000_1000, 1, 1, 6'h00, 0, 0)};
    vecs[11] = '{32'h4031_5093, 16'h0114, 16'h0154, 1'b0,
                 mk(0, 16'h0118, 2, 3, 1, 1, 0, 32'h403, 0, 1, 6'h0D, 0, 0)};
    vecs[12] = '{BADOP,         16'h0114, 16'h0154, 1'b1,
                 mk(0, 16'h0118, 0, 0, 0, 0, 0, 32'h0, 0, 1, 6'h00, 0, 0)};
    vecs[13] = '{32'h0140_006F, 16'hFFFC, 16'h0154, 1'b0,
                 mk(1, 16'h0010, 0, 20, 0, 1, 0, 32'h14, 2, 1, 6'h1F, 0, 0)};

    // Reset state and decode during reset
    reset = 1'b0; PC = 16'h0114; JALR_target = 16'h0154; branch = 1'b0;
    instruction = ADDI;
    #2;
    check_flag("illegal_in_reset", 1'b0);
    check_dec("decode_in_reset", vecs[0].exp);

    // Illegal presented across an edge while reset is low: reset wins
    instruction = BADOP;
    @(posedge clock); #1;
    check_flag("reset_wins", 1'b0);

    @(negedge clock); reset = 1'b1; instruction = ADDI;
    @(posedge clock); #1;
    check_flag("legal_no_set", 1'b0);

    @(negedge clock); instruction = BADOP; #1;
    check_flag("before_edge", 1'b0);
    @(posedge clock); #1;
    check_flag("illegal_set", 1'b1);

    @(negedge clock); instruction = ADDI;
    repeat (3) @(posedge clock);
    #1;
    check_flag("illegal_sticky", 1'b1);

    @(negedge clock); #2; reset = 1'b0; #1;
    check_flag("async_clear", 1'b0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check_flag("stays_clear", 1'b0);

    // Directed vector table
    for (int v = 0; v < 14; v++) begin
      @(negedge clock);
      instruction = vecs[v].instr; PC = vecs[v].pc;
      JALR_target = vecs[v].jt;    branch = vecs[v].br;
      #1;
      check_dec($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Randomized instructions against the model
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    for (int n = 0; n < 400; n++) begin
      int k;
      @(negedge clock);
      r = $urandom;
      k = int'($urandom_range(0, 9));
      instruction = (k == 9) ? r : {r[31:7], ops[k]};
      if (k == 1 && $urandom_range(0, 3) == 0) instruction[31:25] = 7'b0100000;
      PC          = 16'($urandom);
      JALR_target = 16'($urandom);
      branch      = 1'($urandom);
      #1;
      check_dec($sformatf("rand%0d", n), model(instruction, PC, JALR_target, branch));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
